instr_fetch_mem: RTL

- Parametrised, pipelined instruction memory; successor to the single-port combinational instruction ROM.
- Sits between the PC/fetch stage and the decode stage of the RISC-V datapath.
- Byte-addressed fetch with valid/ready handshake on both sides, configurable read latency, in-order response buffering and flush.
- Alignment and range fault reporting, plus a program-load write port so benches and boot logic can fill memory.

---
 rtl/instr_fetch_mem_if.sv | 25 ++
 rtl/instr_fetch_mem.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem_if.sv
// Fetch-side handshake bundle between the PC/fetch stage (master) and the
// instruction memory (slave): request channel plus response channel.
interface instr_fetch_mem_if #(
    parameter int ADDR_W = 32,
    parameter int BITS   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [BITS-1:0]   resp_data;
    logic [ADDR_W-1:0] resp_addr;
    logic [1:0]        resp_fault;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr, resp_fault
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction memory: synchronous-read RAM behind a valid/ready
// fetch interface, optional output register (LATENCY=2), in-order response
// buffer of LATENCY+1 entries, flush, fault reporting and a program-load port.
module instr_fetch_mem #(
    parameter int          BITS    = 32,
    parameter int          DEPTH   = 2048,
    parameter int          ADDR_W  = 32,
    parameter int          LATENCY = 1,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_fetch_mem_if.slave         bus,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [BITS-1:0]          prog_data
);
    localparam int OFS   = $clog2(BITS / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BUF_N = LATENCY + 1;
    localparam int CNT_W = $clog2(BUF_N + 1);
    localparam int PTR_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef struct packed {
        logic [BITS-1:0]   data;
        logic [ADDR_W-1:0] addr;
        fault_e            fault;
    } entry_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage
    logic [BITS-1:0] mem [DEPTH];
    logic [BITS-1:0] ram_q;

    // Occupancy = reads in the pipeline + entries waiting in the buffer
    logic [CNT_W-1:0] count;

    // Pipeline stage 1 (RAM output stage)
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    fault_e            s1_fault;
    entry_t            s1_entry;

    // Last pipeline stage feeding the buffer / output
    logic   last_valid;
    entry_t last_entry;

    // Response buffer
    entry_t           buf_q [BUF_N];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fcnt;

    logic   accept;
    logic   consume;
    logic   push;
    logic   pop;
    logic   fifo_empty;
    logic   rd_en;
    fault_e req_fault;
    entry_t head;
    logic [IDX_W-1:0] rd_idx;

    // Request decode: misalignment outranks out-of-range
    always_comb begin
        req_fault = FAULT_OK;
        if ((bus.req_addr & ADDR_W'((1 << OFS) - 1)) != '0)
            req_fault = FAULT_MISALIGN;
        else if ((bus.req_addr >> OFS) >= ADDR_W'(DEPTH))
            req_fault = FAULT_RANGE;
    end

    assign rd_idx        = bus.req_addr[OFS +: IDX_W];
    assign bus.req_ready = !rst && !flush && (count < CNT_W'(BUF_N));
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_en         = accept && (req_fault == FAULT_OK);

    // Program-load write and synchronous read; no reset so it maps to block RAM
    // NOTE: both use <=, so a read of the word being written returns the old
    // word (read-first); memory contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
        if (rd_en)
            ram_q <= mem[rd_idx];
    end

    // Stage 1 tracks the address/fault of the read now landing in ram_q
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_fault <= FAULT_OK;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= bus.req_addr;
                s1_fault <= req_fault;
            end
        end
    end

    assign s1_entry = '{
        data:  (s1_fault == FAULT_OK) ? ram_q : BITS'(NOP),
        addr:  s1_addr,
        fault: s1_fault
    };

    generate
        if (LATENCY == 2) begin : g_out_reg
            logic   s2_valid;
            entry_t s2_entry;

            // Extra output register stage; payload needs no reset as it is gated by valid
            always_ff @(posedge clk) begin
                if (rst || flush)
                    s2_valid <= 1'b0;
                else
                    s2_valid <= s1_valid;
                s2_entry <= s1_entry;
            end

            assign last_valid = s2_valid;
            assign last_entry = s2_entry;
        end else begin : g_no_out_reg
            assign last_valid = s1_valid;
            assign last_entry = s1_entry;
        end
    endgenerate

    // The last stage bypasses the buffer only when the buffer is empty and the
    // consumer takes it; otherwise it is parked so the output stays stable.
    assign fifo_empty     = (fcnt == '0);
    assign head           = fifo_empty ? last_entry : buf_q[rd_ptr];
    assign bus.resp_valid = !fifo_empty || last_valid;
    assign consume        = bus.resp_valid && bus.resp_ready;
    assign push           = last_valid && !(fifo_empty && consume);
    assign pop            = !fifo_empty && consume;

    assign bus.resp_data  = bus.resp_valid ? head.data  : '0;
    assign bus.resp_addr  = bus.resp_valid ? head.addr  : '0;
    assign bus.resp_fault = bus.resp_valid ? head.fault : FAULT_OK;

    // Buffer payload; stale slots are harmless because pointers define content
    always_ff @(posedge clk) begin
        if (push)
            buf_q[wr_ptr] <= last_entry;
    end

    // Buffer pointers and fill level
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            fcnt <= fcnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Registered occupancy that gates req_ready
    always_ff @(posedge clk) begin
        if (rst || flush)
            count <= '0;
        else
            count <= count + CNT_W'(accept) - CNT_W'(consume);
    end
endmodule
